// File: rtl/id_ex_operand_stage_if.sv
// ALU operation encoding and the bus bundle between decode, the ID/EX operand
// stage, EX and the MEM/WB forwarding taps.
// slave  : the view taken by id_ex_operand_stage
// master : the view taken by the surrounding pipeline (or a testbench)

package alu_pkg;
  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_e;
endpackage

interface id_ex_operand_stage_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
);
  import alu_pkg::*;

  logic                  flush;
  // decode side
  logic                  id_valid;
  logic                  id_ready;
  logic [XLEN-1:0]       id_pc;
  logic [REG_ADDR_W-1:0] id_rs1_addr;
  logic [REG_ADDR_W-1:0] id_rs2_addr;
  logic [XLEN-1:0]       id_rs1_data;
  logic [XLEN-1:0]       id_rs2_data;
  logic                  id_uses_rs1;
  logic                  id_uses_rs2;
  logic [XLEN-1:0]       id_imm;
  logic [1:0]            id_a_sel;
  logic                  id_b_sel;
  alu_e                  id_alu_sel;
  logic [REG_ADDR_W-1:0] id_rd_addr;
  logic                  id_rd_we;
  logic                  id_is_load;
  // execute side
  logic                  ex_valid;
  logic                  ex_ready;
  logic [XLEN-1:0]       ex_a;
  logic [XLEN-1:0]       ex_b;
  alu_e                  ex_alu_sel;
  logic [XLEN-1:0]       ex_store_data;
  logic [XLEN-1:0]       ex_pc;
  logic [REG_ADDR_W-1:0] ex_rd_addr;
  logic                  ex_rd_we;
  logic                  ex_is_load;
  // forwarding taps
  logic                  mem_rd_we;
  logic [REG_ADDR_W-1:0] mem_rd_addr;
  logic [XLEN-1:0]       mem_rd_data;
  logic                  wb_rd_we;
  logic [REG_ADDR_W-1:0] wb_rd_addr;
  logic [XLEN-1:0]       wb_rd_data;

  modport slave (
    input  flush,
    input  id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
    input  id_uses_rs1, id_uses_rs2, id_imm, id_a_sel, id_b_sel, id_alu_sel,
    input  id_rd_addr, id_rd_we, id_is_load,
    output id_ready,
    output ex_valid, ex_a, ex_b, ex_alu_sel, ex_store_data, ex_pc,
    output ex_rd_addr, ex_rd_we, ex_is_load,
    input  ex_ready,
    input  mem_rd_we, mem_rd_addr, mem_rd_data,
    input  wb_rd_we, wb_rd_addr, wb_rd_data
  );

  modport master (
    output flush,
    output id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_rs1_data, id_rs2_data,
    output id_uses_rs1, id_uses_rs2, id_imm, id_a_sel, id_b_sel, id_alu_sel,
    output id_rd_addr, id_rd_we, id_is_load,
    input  id_ready,
    input  ex_valid, ex_a, ex_b, ex_alu_sel, ex_store_data, ex_pc,
    input  ex_rd_addr, ex_rd_we, ex_is_load,
    output ex_ready,
    output mem_rd_we, mem_rd_addr, mem_rd_data,
    output wb_rd_we, wb_rd_addr, wb_rd_data
  );
endinterface

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register and operand network for the execute-stage ALU.
// Captures decoded instructions, bypasses WB at capture, forwards MEM/WB into
// the registered operands and stalls decode on unresolvable RAW hazards.
// Optional feature macro: FORWARDING_EN
//   defined   : MEM/WB forwarding into EX operands, stall only on load-use
//   undefined : no forwarding, stall on any pending producer in EX or MEM

module id_ex_operand_stage
  import alu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  id_ex_operand_stage_if.slave   bus
);

  localparam logic [REG_ADDR_W-1:0] X0 = '0;

  // EX-stage registers
  logic                  ex_valid_reg;
  logic [XLEN-1:0]       ex_pc_reg;
  logic [XLEN-1:0]       ex_src_val_reg [2];
  logic [XLEN-1:0]       ex_imm_reg;
  logic [1:0]            ex_a_sel_reg;
  logic                  ex_b_sel_reg;
  alu_e                  ex_alu_sel_reg;
  logic [REG_ADDR_W-1:0] ex_rd_addr_reg;
  logic                  ex_rd_we_reg;
  logic                  ex_is_load_reg;

  // Per-source views of the decode inputs (index 0 = rs1, 1 = rs2)
  logic [REG_ADDR_W-1:0] id_src_addr [2];
  logic                  id_src_use  [2];
  logic [XLEN-1:0]       id_src_data [2];
  logic [XLEN-1:0]       cap_val     [2];
  logic [XLEN-1:0]       fwd_val     [2];
  logic                  dep_ex      [2];

  logic advance;
  logic hazard;
  logic capture;

  assign id_src_addr[0] = bus.id_rs1_addr;
  assign id_src_addr[1] = bus.id_rs2_addr;
  assign id_src_use[0]  = bus.id_uses_rs1;
  assign id_src_use[1]  = bus.id_uses_rs2;
  assign id_src_data[0] = bus.id_rs1_data;
  assign id_src_data[1] = bus.id_rs2_data;

`ifdef FORWARDING_EN
  // Source indices are only needed at EX when forwarding is available
  logic [REG_ADDR_W-1:0] ex_src_addr_reg [2];
  logic                  fwd_mem_hit     [2];
  logic                  fwd_wb_hit      [2];
`else
  logic                  dep_mem         [2];
  logic                  unused_mem_data;
  assign unused_mem_data = ^bus.mem_rd_data;
`endif

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      // WB writes land in the regfile this cycle, so the read data is stale
      assign cap_val[gi] = (bus.wb_rd_we && bus.wb_rd_addr == id_src_addr[gi] &&
                            id_src_addr[gi] != X0) ? bus.wb_rd_data : id_src_data[gi];

      // Decode source depends on the instruction currently held in EX
      assign dep_ex[gi] = id_src_use[gi] && ex_valid_reg && ex_rd_we_reg &&
                          ex_rd_addr_reg != X0 && id_src_addr[gi] == ex_rd_addr_reg;

`ifdef FORWARDING_EN
      assign fwd_mem_hit[gi] = bus.mem_rd_we && ex_src_addr_reg[gi] != X0 &&
                               bus.mem_rd_addr == ex_src_addr_reg[gi];
      assign fwd_wb_hit[gi]  = bus.wb_rd_we && ex_src_addr_reg[gi] != X0 &&
                               bus.wb_rd_addr == ex_src_addr_reg[gi];
      // MEM is the younger producer and takes precedence over WB
      assign fwd_val[gi] = fwd_mem_hit[gi] ? bus.mem_rd_data :
                           fwd_wb_hit[gi]  ? bus.wb_rd_data  : ex_src_val_reg[gi];
`else
      assign dep_mem[gi] = id_src_use[gi] && bus.mem_rd_we && bus.mem_rd_addr != X0 &&
                           id_src_addr[gi] == bus.mem_rd_addr;
      assign fwd_val[gi] = ex_src_val_reg[gi];
`endif
    end
  endgenerate

`ifdef FORWARDING_EN
  // Only a load in EX cannot be forwarded in time
  assign hazard = ex_is_load_reg && (dep_ex[0] || dep_ex[1]);
`else
  // Wait until the producer has reached WB, where the capture bypass covers it
  assign hazard = dep_ex[0] || dep_ex[1] || dep_mem[0] || dep_mem[1];
`endif

  assign advance      = !ex_valid_reg || bus.ex_ready;
  assign capture      = bus.id_valid && !hazard;
  assign bus.id_ready = advance && !hazard;

  // EX register update: reset, then flush, then advance, else hold
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid_reg      <= 1'b0;
      ex_pc_reg         <= '0;
      ex_src_val_reg[0] <= '0;
      ex_src_val_reg[1] <= '0;
      ex_imm_reg        <= '0;
      ex_a_sel_reg      <= '0;
      ex_b_sel_reg      <= 1'b0;
      ex_alu_sel_reg    <= ALU_ADD;
      ex_rd_addr_reg    <= '0;
      ex_rd_we_reg      <= 1'b0;
      ex_is_load_reg    <= 1'b0;
`ifdef FORWARDING_EN
      ex_src_addr_reg[0] <= '0;
      ex_src_addr_reg[1] <= '0;
`endif
    end else if (bus.flush) begin
      ex_valid_reg <= 1'b0;
    end else if (advance) begin
      ex_valid_reg <= capture;
      if (capture) begin
        ex_pc_reg         <= bus.id_pc;
        ex_src_val_reg[0] <= cap_val[0];
        ex_src_val_reg[1] <= cap_val[1];
        ex_imm_reg        <= bus.id_imm;
        ex_a_sel_reg      <= bus.id_a_sel;
        ex_b_sel_reg      <= bus.id_b_sel;
        ex_alu_sel_reg    <= bus.id_alu_sel;
        ex_rd_addr_reg    <= bus.id_rd_addr;
        ex_rd_we_reg      <= bus.id_rd_we;
        ex_is_load_reg    <= bus.id_is_load;
`ifdef FORWARDING_EN
        ex_src_addr_reg[0] <= bus.id_rs1_addr;
        ex_src_addr_reg[1] <= bus.id_rs2_addr;
`endif
      end
    end
  end

  // Operand selection for the ALU
  always_comb begin
    bus.ex_a = '0;
    case (ex_a_sel_reg)
      2'd0:    bus.ex_a = fwd_val[0];
      2'd1:    bus.ex_a = ex_pc_reg;
      default: bus.ex_a = '0;
    endcase
    bus.ex_b = ex_b_sel_reg ? ex_imm_reg : fwd_val[1];
  end

  assign bus.ex_valid      = ex_valid_reg;
  assign bus.ex_store_data = fwd_val[1];
  assign bus.ex_alu_sel    = ex_alu_sel_reg;
  assign bus.ex_pc         = ex_pc_reg;
  assign bus.ex_rd_addr    = ex_rd_addr_reg;
  assign bus.ex_rd_we      = ex_rd_we_reg;
  assign bus.ex_is_load    = ex_is_load_reg;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: directed literal scenarios
// followed by randomized traffic checked each cycle against an
// instruction-level model of the stage.

module tb_id_ex_operand_stage;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_ex_operand_stage_if #(.XLEN(32), .REG_ADDR_W(5)) bus ();

  id_ex_operand_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: the instruction sitting in EX ----------
  typedef struct packed {
    logic [31:0] pc, v1, v2, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [1:0]  asel;
    logic        bsel;
    alu_e        alu;
    logic        we, ld;
  } ins_t;

  ins_t m_ex;
  bit   m_valid = 1'b0;
  bit   m_init  = 1'b0;

  // value an EX source must present, given what MEM/WB show right now
  function automatic logic [31:0] m_fwd(input logic [4:0] rs, input logic [31:0] held);
`ifdef FORWARDING_EN
    if (rs != 0 && bus.mem_rd_we && bus.mem_rd_addr == rs) return bus.mem_rd_data;
    if (rs != 0 && bus.wb_rd_we && bus.wb_rd_addr == rs) return bus.wb_rd_data;
`endif
    return held;
  endfunction

  function automatic bit m_reads(input logic [4:0] r);
    return (bus.id_uses_rs1 && bus.id_rs1_addr == r) || (bus.id_uses_rs2 && bus.id_rs2_addr == r);
  endfunction

  function automatic bit m_hazard();
    bit dep_ex;
    dep_ex = m_valid && m_ex.we && m_ex.rd != 0 && m_reads(m_ex.rd);
`ifdef FORWARDING_EN
    return dep_ex && m_ex.ld;
`else
    return dep_ex || (bus.mem_rd_we && bus.mem_rd_addr != 0 && m_reads(bus.mem_rd_addr));
`endif
  endfunction

  function automatic logic [31:0] m_a();
    if (m_ex.asel == 2'd0) return m_fwd(m_ex.rs1, m_ex.v1);
    if (m_ex.asel == 2'd1) return m_ex.pc;
    return 32'd0;
  endfunction

  function automatic logic [31:0] m_rf(input logic [4:0] rs, input logic [31:0] rd_data);
    if (rs != 0 && bus.wb_rd_we && bus.wb_rd_addr == rs) return bus.wb_rd_data;
    return rd_data;
  endfunction

  // Model update on each rising edge
  always @(posedge clk) begin : mdl
    bit   h;
    ins_t c;
    h = m_hazard();
    c = m_ex;
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_ex    <= '0;
      m_init  <= 1'b1;
    end else if (bus.flush) begin
      m_valid <= 1'b0;
    end else if (!m_valid || bus.ex_ready) begin
      m_valid <= bus.id_valid && !h;
      if (bus.id_valid && !h) begin
        c.pc   = bus.id_pc;
        c.rs1  = bus.id_rs1_addr;
        c.rs2  = bus.id_rs2_addr;
        c.v1   = m_rf(bus.id_rs1_addr, bus.id_rs1_data);
        c.v2   = m_rf(bus.id_rs2_addr, bus.id_rs2_data);
        c.imm  = bus.id_imm;
        c.asel = bus.id_a_sel;
        c.bsel = bus.id_b_sel;
        c.alu  = bus.id_alu_sel;
        c.rd   = bus.id_rd_addr;
        c.we   = bus.id_rd_we;
        c.ld   = bus.id_is_load;
        m_ex  <= c;
      end
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (m_init && rst_n) begin
      chk("ex_valid",   32'(bus.ex_valid), 32'(m_valid));
      chk("id_ready",   32'(bus.id_ready), 32'((!m_valid || bus.ex_ready) && !m_hazard()));
      chk("ex_a",       bus.ex_a, m_a());
      chk("ex_b",       bus.ex_b, m_ex.bsel ? m_ex.imm : m_fwd(m_ex.rs2, m_ex.v2));
      chk("ex_store",   bus.ex_store_data, m_fwd(m_ex.rs2, m_ex.v2));
      chk("ex_pc",      bus.ex_pc, m_ex.pc);
      chk("ex_alu_sel", 32'(bus.ex_alu_sel), 32'(m_ex.alu));
      chk("ex_rd",      32'(bus.ex_rd_addr), 32'(m_ex.rd));
      chk("ex_rd_we",   32'(bus.ex_rd_we), 32'(m_ex.we));
      chk("ex_is_load", 32'(bus.ex_is_load), 32'(m_ex.ld));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_taps();
    bus.mem_rd_we = 1'b0; bus.mem_rd_addr = '0; bus.mem_rd_data = '0;
    bus.wb_rd_we  = 1'b0; bus.wb_rd_addr  = '0; bus.wb_rd_data  = '0;
  endtask

  task automatic set_id(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] imm,
                        input logic [1:0] asel, input logic bsel, input logic [4:0] rd,
                        input logic we, input logic ld);
    bus.id_pc = pc; bus.id_rs1_addr = rs1; bus.id_rs2_addr = rs2;
    bus.id_rs1_data = v1; bus.id_rs2_data = v2; bus.id_imm = imm;
    bus.id_uses_rs1 = (rs1 != 0); bus.id_uses_rs2 = (rs2 != 0);
    bus.id_a_sel = asel; bus.id_b_sel = bsel; bus.id_alu_sel = ALU_ADD;
    bus.id_rd_addr = rd; bus.id_rd_we = we; bus.id_is_load = ld;
  endtask

  // Push one instruction into EX, then hold EX with ex_ready low
  task automatic issue(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] imm,
                       input logic [1:0] asel, input logic bsel, input logic [4:0] rd,
                       input logic we, input logic ld);
    set_id(pc, rs1, rs2, v1, v2, imm, asel, bsel, rd, we, ld);
    bus.id_valid = 1'b1;
    bus.ex_ready = 1'b1;
    tick();
    bus.id_valid = 1'b0;
    bus.ex_ready = 1'b0;
    idle_taps();
  endtask

  initial begin
    bus.flush = 1'b0;
    bus.ex_ready = 1'b1;
    bus.id_valid = 1'b0;
    set_id(32'h0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    idle_taps();

    // reset state
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    #2;
    chk("rst_id_ready", 32'(bus.id_ready), 32'd1);
    chk("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
    chk("rst_alu_sel",  32'(bus.ex_alu_sel), 32'(ALU_ADD));
    chk("rst_ex_pc",    bus.ex_pc, 32'd0);

    // MEM forward into rs1
    issue(32'h100, 5'd1, 5'd0, 32'h55, 32'h0, 32'h4, 2'd0, 1'b1, 5'd2, 1'b1, 1'b0);
    bus.mem_rd_we = 1'b1; bus.mem_rd_addr = 5'd1; bus.mem_rd_data = 32'h10;
    #2;
`ifdef FORWARDING_EN
    chk("fwd_mem_a", bus.ex_a, 32'h10);
`else
    chk("fwd_mem_a", bus.ex_a, 32'h55);
`endif
    chk("fwd_imm_b", bus.ex_b, 32'h4);
    chk("fwd_pc",    bus.ex_pc, 32'h100);
    tick();

    // MEM and WB both write x3: MEM wins
    issue(32'h104, 5'd0, 5'd3, 32'h0, 32'h77, 32'h0, 2'd2, 1'b0, 5'd4, 1'b1, 1'b0);
    bus.mem_rd_we = 1'b1; bus.mem_rd_addr = 5'd3; bus.mem_rd_data = 32'hA;
    bus.wb_rd_we  = 1'b1; bus.wb_rd_addr  = 5'd3; bus.wb_rd_data  = 32'hB;
    #2;
`ifdef FORWARDING_EN
    chk("mem_over_wb_b",     bus.ex_b, 32'hA);
    chk("mem_over_wb_store", bus.ex_store_data, 32'hA);
`else
    chk("mem_over_wb_b",     bus.ex_b, 32'h77);
    chk("mem_over_wb_store", bus.ex_store_data, 32'h77);
`endif
    chk("zero_sel_a", bus.ex_a, 32'd0);
    tick();

    // x0 never forwarded
    issue(32'h108, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0, 5'd6, 1'b1, 1'b0);
    bus.mem_rd_we = 1'b1; bus.mem_rd_addr = 5'd0; bus.mem_rd_data = 32'hDEAD;
    bus.wb_rd_we  = 1'b1; bus.wb_rd_addr  = 5'd0; bus.wb_rd_data  = 32'hBEEF;
    #2;
    chk("x0_a", bus.ex_a, 32'd0);
    tick();

    // WB bypass at capture overrides stale regfile data
    idle_taps();
    set_id(32'h10C, 5'd4, 5'd0, 32'h9, 32'h0, 32'h0, 2'd0, 1'b0, 5'd9, 1'b1, 1'b0);
    bus.wb_rd_we = 1'b1; bus.wb_rd_addr = 5'd4; bus.wb_rd_data = 32'h1234;
    bus.id_valid = 1'b1; bus.ex_ready = 1'b1;
    tick();
    bus.id_valid = 1'b0; bus.ex_ready = 1'b0;
    idle_taps();
    #2;
    chk("wb_bypass_a", bus.ex_a, 32'h1234);
    tick();

    // load-use stall of one cycle
    issue(32'h200, 5'd0, 5'd0, 32'h0, 32'h0, 32'h8, 2'd0, 1'b1, 5'd5, 1'b1, 1'b1);
    set_id(32'h240, 5'd5, 5'd0, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0, 5'd8, 1'b1, 1'b0);
    bus.id_valid = 1'b1; bus.ex_ready = 1'b1;
    #2;
    chk("lu_id_ready0", 32'(bus.id_ready), 32'd0);
    tick();
    #2;
    chk("lu_bubble",    32'(bus.ex_valid), 32'd0);
    chk("lu_id_ready1", 32'(bus.id_ready), 32'd1);
    tick();
    #2;
    chk("lu_enter_v",  32'(bus.ex_valid), 32'd1);
    chk("lu_enter_pc", bus.ex_pc, 32'h240);

    // backpressure holds EX, then flush kills it
    tick();
    set_id(32'h300, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 2'd1, 1'b0, 5'd10, 1'b1, 1'b0);
    bus.id_valid = 1'b1; bus.ex_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #2;
      chk("bp_id_ready", 32'(bus.id_ready), 32'd0);
      chk("bp_ex_pc",    bus.ex_pc, 32'h240);
      chk("bp_ex_valid", 32'(bus.ex_valid), 32'd1);
      tick();
    end
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0; bus.id_valid = 1'b0;
    #2;
    chk("flush_valid", 32'(bus.ex_valid), 32'd0);
    chk("flush_pc",    bus.ex_pc, 32'h240);
    tick();

`ifndef FORWARDING_EN
    // stall on EX then MEM producer, abandoned by reset
    issue(32'h400, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0, 5'd7, 1'b1, 1'b0);
    set_id(32'h404, 5'd0, 5'd7, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0, 5'd11, 1'b1, 1'b0);
    bus.id_valid = 1'b1; bus.ex_ready = 1'b1;
    #2;
    chk("nf_stall1", 32'(bus.id_ready), 32'd0);
    tick();
    bus.mem_rd_we = 1'b1; bus.mem_rd_addr = 5'd7; bus.mem_rd_data = 32'h77;
    #2;
    chk("nf_stall2", 32'(bus.id_ready), 32'd0);
    chk("nf_bubble", 32'(bus.ex_valid), 32'd0);
    rst_n = 1'b0;
    bus.mem_rd_we = 1'b0;
    tick();
    rst_n = 1'b1;
    #2;
    chk("nf_rst_valid", 32'(bus.ex_valid), 32'd0);
    chk("nf_rst_ready", 32'(bus.id_ready), 32'd1);
    tick();
`endif

    // randomized traffic, small register space to provoke dependencies
    for (int i = 0; i < 3000; i++) begin
      rst_n        = ($urandom_range(0, 199) != 0);
      bus.flush    = ($urandom_range(0, 15) == 0);
      bus.ex_ready = ($urandom_range(0, 3) != 0);
      bus.id_valid = ($urandom_range(0, 3) != 0);
      bus.id_pc       = $urandom;
      bus.id_rs1_addr = 5'($urandom_range(0, 7));
      bus.id_rs2_addr = 5'($urandom_range(0, 7));
      bus.id_rs1_data = $urandom;
      bus.id_rs2_data = $urandom;
      bus.id_uses_rs1 = 1'($urandom_range(0, 1));
      bus.id_uses_rs2 = 1'($urandom_range(0, 1));
      bus.id_imm      = $urandom;
      bus.id_a_sel    = 2'($urandom_range(0, 3));
      bus.id_b_sel    = 1'($urandom_range(0, 1));
      bus.id_alu_sel  = alu_e'(4'($urandom_range(0, 10)));
      bus.id_rd_addr  = 5'($urandom_range(0, 7));
      bus.id_rd_we    = 1'($urandom_range(0, 1));
      bus.id_is_load  = 1'($urandom_range(0, 1));
      bus.mem_rd_we   = 1'($urandom_range(0, 1));
      bus.mem_rd_addr = 5'($urandom_range(0, 7));
      bus.mem_rd_data = $urandom;
      bus.wb_rd_we    = 1'($urandom_range(0, 1));
      bus.wb_rd_addr  = 5'($urandom_range(0, 7));
      bus.wb_rd_data  = $urandom;
      tick();
    end

    rst_n = 1'b1;
    bus.flush = 1'b0;
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
